// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image pipeline blocks: pixel-pair layout,
// arbiter state encoding, default frame geometry and a counter-width helper.
// ---------------------------------------------------------------------------
package img_pkg;

   // A pixel pair is {R0,G0,B0,R1,G1,B1}, eight bits per channel.
   localparam int PIX_PAIR_W = 48;
   localparam int CH_W       = 8;
   localparam int R0_LSB     = 40;
   localparam int G0_LSB     = 32;
   localparam int B0_LSB     = 24;
   localparam int R1_LSB     = 16;
   localparam int G1_LSB     = 8;
   localparam int B1_LSB     = 0;

   // Frame geometry of the existing image_read/image_write flow.
   localparam int DEF_WIDTH  = 768;
   localparam int DEF_HEIGHT = 512;
   localparam int DEF_GAP    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_e;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_line_arb.sv
// ---------------------------------------------------------------------------
// pixel_line_arb
// Shares one pixel-pair sink between two sources, one full image row at a
// time. A row owner is picked round-robin, its WIDTH/2 beats are forwarded
// through one register stage, then the sink stays idle for GAP cycles.
//
// Ports
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   req0/req1                source has a full row ready
//   valid0/valid1            source presents a pixel pair (used only when granted)
//   pix0/pix1                packed pixel pair {R0,G0,B0,R1,G1,B1}
//   grant0/grant1            row ownership, one-hot or zero
//   data_write               output beat strobe
//   DATA_WRITE_R0..B1        registered pixel pair of the granted source
//   line_done/frame_done     pulses alongside the last beat of a row / frame
//   line_idx                 row currently being (or next to be) transferred
// ---------------------------------------------------------------------------
module pixel_line_arb
   import img_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int GAP    = DEF_GAP
)(
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req0,
   input  logic                      req1,
   input  logic                      valid0,
   input  logic                      valid1,
   input  logic [PIX_PAIR_W-1:0]     pix0,
   input  logic [PIX_PAIR_W-1:0]     pix1,
   output logic                      grant0,
   output logic                      grant1,
   output logic                      data_write,
   output logic [CH_W-1:0]           DATA_WRITE_R0,
   output logic [CH_W-1:0]           DATA_WRITE_G0,
   output logic [CH_W-1:0]           DATA_WRITE_B0,
   output logic [CH_W-1:0]           DATA_WRITE_R1,
   output logic [CH_W-1:0]           DATA_WRITE_G1,
   output logic [CH_W-1:0]           DATA_WRITE_B1,
   output logic                      line_done,
   output logic                      frame_done,
   output logic [cnt_w(HEIGHT)-1:0]  line_idx
);

   localparam int BEATS  = WIDTH / 2;
   localparam int BEAT_W = cnt_w(BEATS);
   localparam int LINE_W = cnt_w(HEIGHT);
   localparam int GAP_W  = cnt_w(GAP);

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(HEIGHT - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   if ((WIDTH % 2) != 0 || WIDTH < 2 || HEIGHT < 1 || GAP < 0) begin : g_bad_params
      $error("pixel_line_arb: WIDTH must be even and >= 2, HEIGHT >= 1, GAP >= 0");
   end

   arb_state_e              r_state;
   arb_state_e              w_state_nxt;
   logic                    r_grant0;
   logic                    r_grant1;
   logic                    w_grant0_nxt;
   logic                    w_grant1_nxt;
   logic [BEAT_W-1:0]       r_beat_cnt;
   logic [BEAT_W-1:0]       w_beat_nxt;
   logic [GAP_W-1:0]        r_gap_cnt;
   logic [GAP_W-1:0]        w_gap_nxt;
   logic                    r_last_served;
   logic                    w_last_srv_nxt;
   logic [LINE_W-1:0]       r_line_idx;
   logic [LINE_W-1:0]       w_line_nxt;
   logic                    w_pick1;

   logic                    r_data_write;
   logic [PIX_PAIR_W-1:0]   r_pix;
   logic                    r_line_done;
   logic                    r_frame_done;

   logic                    w_accept;
   logic                    w_last_beat;
   logic [PIX_PAIR_W-1:0]   w_pix_sel;

   // Grants are only ever high in XFER, so a granted valid is a beat.
   assign w_accept    = (r_grant0 & valid0) | (r_grant1 & valid1);
   assign w_last_beat = w_accept & (r_beat_cnt == BEAT_LAST);
   assign w_pix_sel   = r_grant1 ? pix1 : pix0;

   // -------------------------------------------------------------------------
   // Next-state and arbitration
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal takes its hold value first, so no path through the
      // case can leave one unassigned and infer a latch.
      w_state_nxt    = r_state;
      w_grant0_nxt   = r_grant0;
      w_grant1_nxt   = r_grant1;
      w_beat_nxt     = r_beat_cnt;
      w_gap_nxt      = r_gap_cnt;
      w_last_srv_nxt = r_last_served;
      w_line_nxt     = r_line_idx;
      w_pick1        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (req0 | req1) begin
               // Source 1 wins alone, or on a tie when source 0 was served last.
               w_pick1      = req1 & (~req0 | ~r_last_served);
               w_grant0_nxt = ~w_pick1;
               w_grant1_nxt = w_pick1;
               w_beat_nxt   = '0;
               w_state_nxt  = ST_XFER;
            end
         end

         ST_XFER: begin
            if (w_last_beat) begin
               w_beat_nxt     = '0;
               w_gap_nxt      = '0;
               w_grant0_nxt   = 1'b0;
               w_grant1_nxt   = 1'b0;
               w_last_srv_nxt = r_grant1;
               w_line_nxt     = (r_line_idx == LINE_LAST) ? '0 : r_line_idx + LINE_W'(1);
               w_state_nxt    = (GAP == 0) ? ST_IDLE : ST_GAP;
            end else if (w_accept) begin
               w_beat_nxt = r_beat_cnt + BEAT_W'(1);
            end
         end

         ST_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_gap_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_gap_nxt = r_gap_cnt + GAP_W'(1);
            end
         end

         default: begin
            w_state_nxt  = ST_IDLE;
            w_grant0_nxt = 1'b0;
            w_grant1_nxt = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values,
         // independent of block ordering.
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Control counters
   // -------------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_grant0      <= 1'b0;
         r_grant1      <= 1'b0;
         r_beat_cnt    <= '0;
         r_gap_cnt     <= '0;
         r_last_served <= 1'b1;
         r_line_idx    <= '0;
      end else begin
         r_grant0      <= w_grant0_nxt;
         r_grant1      <= w_grant1_nxt;
         r_beat_cnt    <= w_beat_nxt;
         r_gap_cnt     <= w_gap_nxt;
         r_last_served <= w_last_srv_nxt;
         r_line_idx    <= w_line_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Output stage: one register between the granted source and the sink
   // -------------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         // NOTE: the pixel register is reset too, because the sink sees
         // DATA_WRITE_* as 0x00 until the first beat; it is a single flop
         // bank, not a memory, so the reset costs nothing in timing.
         r_data_write <= 1'b0;
         r_pix        <= '0;
         r_line_done  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_data_write <= w_accept;
         if (w_accept) begin
            r_pix <= w_pix_sel;
         end
         r_line_done  <= w_last_beat;
         r_frame_done <= w_last_beat & (r_line_idx == LINE_LAST);
      end
   end

   assign grant0        = r_grant0;
   assign grant1        = r_grant1;
   assign data_write    = r_data_write;
   assign DATA_WRITE_R0 = r_pix[R0_LSB +: CH_W];
   assign DATA_WRITE_G0 = r_pix[G0_LSB +: CH_W];
   assign DATA_WRITE_B0 = r_pix[B0_LSB +: CH_W];
   assign DATA_WRITE_R1 = r_pix[R1_LSB +: CH_W];
   assign DATA_WRITE_G1 = r_pix[G1_LSB +: CH_W];
   assign DATA_WRITE_B1 = r_pix[B1_LSB +: CH_W];
   assign line_done     = r_line_done;
   assign frame_done    = r_frame_done;
   assign line_idx      = r_line_idx;

endmodule

// File: doc/pixel_line_arb.md
# pixel_line_arb

Line-granular arbiter that shares the single pixel-pair sink (`image_write`) between two pixel-pair sources (e.g. two `image_read` instances or a reader plus a processing stage). It grants the sink to one source for exactly one image row of WIDTH/2 pixel-pair beats. It forwards that source's pixels as a registered `data_write` stream, then rotates round-robin after an inter-line gap. It counts rows and flags line and frame completion to the testbench/controller.

## Interface
- WIDTH, 768: pixels per row; must be even; beats per line = WIDTH/2
- HEIGHT, 512: rows per frame
- GAP, 4: idle cycles between the last beat of one line and the next grant; 0 allowed

- HCLK  in  1  clock, all logic on rising edge
- HRESETn  in  1  asynchronous active-low reset
- req0 / req1  in  1  source has a full row ready to send
- valid0 / valid1  in  1  source presents a pixel pair this cycle (honoured only while granted)
- pix0 / pix1  in  48  packed pair {R0,G0,B0,R1,G1,B1}, R0 in [47:40]
- grant0 / grant1  out  1  one-hot (or zero) ownership of the sink for the current row
- data_write  out  1  output beat strobe to `image_write`
- DATA_WRITE_R0, G0, B0, R1, G1, B1  out  8 each  registered pixel pair from the granted source
- line_done  out  1  one-cycle pulse with the last beat of a row
- frame_done  out  1  one-cycle pulse with the last beat of row HEIGHT-1
- line_idx  out  clog2(HEIGHT)  row currently being / next to be transferred

## Operation
- States: IDLE, XFER, GAP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that source.
  - Both requests: grant the source not served last. `last_served` resets to 1, so source 0 wins the first tie.
  - Grant registers on entry to XFER.
- XFER:
  - The granted grant_n is held high for the whole row, even if req_n drops.
  - Each cycle with valid_n=1 from the granted source is one beat. beat_cnt (clog2(WIDTH/2) bits) increments.
  - valid from the non-granted source is ignored; its pix is never forwarded.
  - valid=0 cycles stall the row with no timeout.
- Last beat is the one accepted with beat_cnt == WIDTH/2-1. On it:
  - beat_cnt clears.
  - `last_served` is updated.
  - line_idx increments, wrapping HEIGHT-1 -> 0.
  - Next state is GAP, or IDLE when GAP=0.
- GAP: gap counter runs GAP cycles with both grants low, then IDLE. Requests seen during GAP are held off until IDLE.
- No mid-row switching of the granted source.
- Malformed parameters (odd WIDTH, HEIGHT=0) are caught by an elaboration-time assertion.

## Timing
- Reset values: grants 0, data_write 0, all DATA_WRITE_* 0x00, line_done 0, frame_done 0, line_idx 0, state IDLE, beat_cnt 0, gap counter 0, `last_served` 1.
- Grant latency: req seen in IDLE at edge k -> grant high after edge k+1. The source may drive valid in that same cycle.
- Data latency: valid_n accepted at edge k -> data_write and DATA_WRITE_* updated after edge k+1 (one register stage). Data holds its last value when data_write=0.
- line_done (and frame_done, when line_idx was HEIGHT-1) assert in the same cycle as the last data_write.
- The grant drops after the edge that accepts the last beat. The source must not drive valid in the cycle following its last beat.
- Next grant, earliest: GAP+1 cycles after the grant drops.
- Reset mid-row: all state clears asynchronously and the partial row is discarded. After release, arbitration restarts in IDLE with source 0 favoured.

## Structure
- Shared package `img_pkg`:
  - PIX_PAIR_W = 48
  - field offsets for R0..B1
  - state enum {IDLE, XFER, GAP}
  - default WIDTH/HEIGHT, taken from the existing `parameter.v` values
- Single module, no sub-module. The 2-way round-robin pick is a few lines. The beat and gap counters are inline.

## Test plan
Bench parameters: WIDTH=8, HEIGHT=2, GAP=2.
- Reset, then hold req0=1 with valid0 continuous and pix0 = beat index replicated -> grant0 one cycle after req, 4 data_write beats, DATA_WRITE_R0 = 0,1,2,3, line_done with beat 4, grant0 low, 2 idle cycles, then grant0 again.
- req0 and req1 both held -> grants alternate 0,1,0,1. Every row is exactly 4 beats. frame_done pulses on rows 2 and 4, and line_idx wraps 1 -> 0.
- Granted source 1 with valid1 toggling 1,0,1,0,… while valid0=1 with pix0=0xFFFF…FF -> only pix1 values are forwarded, row takes 8 cycles, no 0xFF byte appears.
- req0 pulsed for 1 cycle only -> grant0 held until 4 valid beats complete, then released.
- HRESETn low after 2 beats of a row -> all outputs 0 immediately. After release with req1 only, grant1 and a full 4-beat row follow, and line_idx restarts at 0.
- GAP=0 with both requests held -> the opposite grant rises on the cycle right after the previous grant drops.
